mem_responder: RTL and testbench

Responder end of the CPU data-memory interface. Accepts word-aligned requests carrying physical addresses produced by the address mapper, applies a programmable number of wait states, performs the byte-lane read or write on an internal word array, and returns a response through a valid/ready handshake. On a bus error it reconstructs the faulting virtual address (the inverse of the segment mapping) for the exception unit's BadVAddr.

---
 rtl/mem_responder.sv | 169 ++++++++++++++++
 tb/tb_mem_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Responder end of the CPU data-memory interface. It applies wait states, accesses a word
// array per byte lane, and rebuilds the faulting virtual address on bus errors.
module mem_responder #(
    parameter int DEPTH_WORDS = 2048,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [3:0]  req_be_i,
    input  logic [1:0]  req_seg_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] rsp_badvaddr_o
);
    // state | meaning
    // IDLE  | ready for one request
    // WAIT  | request captured, counting down wait states
    // RESP  | access done, response held until consumed
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_W   = 30'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
    localparam logic [31:0] DATA_BASE = 32'h1001_0000;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  seg_q, seg_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_badvaddr_q, rsp_badvaddr_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          enter_resp;
    logic          fault;
    logic          mem_we;
    logic [AW-1:0] acc_idx;
    logic [31:0]   rd_word;
    logic [31:0]   lane_mask;
    logic [31:0]   vaddr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        be_d    = be_q;
        seg_d   = seg_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    we_d    = req_we_i;
                    be_d    = req_be_i;
                    seg_d   = req_seg_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The *_d copies are the access operands: live inputs on a zero-wait accept, captured otherwise.
    assign enter_resp = (state_q != ST_RESP) && (state_d == ST_RESP);
    assign fault      = (be_d == 4'b0000) || (addr_d[1:0] != 2'b00) || (addr_d[31:2] >= DEPTH_W);
    assign acc_idx    = addr_d[AW+1:2];
    assign rd_word    = mem_q[acc_idx];
    assign lane_mask  = {{8{be_d[3]}}, {8{be_d[2]}}, {8{be_d[1]}}, {8{be_d[0]}}};
    assign mem_we     = enter_resp && we_d && !fault;

    always_comb begin
        case (seg_d)
            2'd0:    vaddr = addr_d + TEXT_BASE;
            2'd1:    vaddr = addr_d + DATA_BASE;
            default: vaddr = addr_d;
        endcase
    end

    always_comb begin
        rsp_rdata_d    = rsp_rdata_q;
        rsp_err_d      = rsp_err_q;
        rsp_badvaddr_d = rsp_badvaddr_q;
        if (enter_resp) begin
            rsp_err_d      = fault;
            rsp_badvaddr_d = fault ? vaddr : 32'd0;
            rsp_rdata_d    = (fault || we_d) ? 32'd0 : (rd_word & lane_mask);
        end
        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 4'd0;
            we_q           <= 1'b0;
            be_q           <= 4'd0;
            seg_q          <= 2'd0;
            addr_q         <= 32'd0;
            wdata_q        <= 32'd0;
            req_ready_q    <= 1'b0;
            rsp_rdata_q    <= 32'd0;
            rsp_err_q      <= 1'b0;
            rsp_badvaddr_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            we_q           <= we_d;
            be_q           <= be_d;
            seg_q          <= seg_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            req_ready_q    <= req_ready_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_err_q      <= rsp_err_d;
            rsp_badvaddr_q <= rsp_badvaddr_d;
        end
    end

    // Array contents survive reset; only enabled lanes of a legal write are touched.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_d[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= wdata_d[8*i +: 8];
                end
            end
        end
    end

    assign req_ready_o    = req_ready_q;
    assign rsp_valid_o    = (state_q == ST_RESP);
    assign rsp_rdata_o    = rsp_rdata_q;
    assign rsp_err_o      = rsp_err_q;
    assign rsp_badvaddr_o = rsp_badvaddr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a transaction-level model checked every cycle, plus directed
// literal expectations and a second zero-wait-state instance.
module tb_mem_responder;
    localparam int DEPTH = 2048;
    localparam int WAITC = 2;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_we, rsp_ready;
    logic [3:0]  req_be;
    logic [1:0]  req_seg;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, rsp_badvaddr;

    logic        req_valid0, rsp_ready0;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0, rsp_badvaddr0;

    int total = 0;
    int bad   = 0;

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_be_i(req_be), .req_seg_i(req_seg), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_badvaddr_o(rsp_badvaddr)
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_we_i(req_we),
        .req_be_i(req_be), .req_seg_i(req_seg), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0), .rsp_rdata_o(rsp_rdata0),
        .rsp_err_o(rsp_err0), .rsp_badvaddr_o(rsp_badvaddr0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [31:0] mem_m [int];
    int          cyc = 0;
    int          rel_cnt = 0;
    bit          busy = 0;
    int          acc_cyc;
    bit          e_we, e_err, e_rknown;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_rdata, e_bva;
    bit          prev_valid = 0;
    int          dut_lat;
    logic [31:0] last_rdata, last_bva;
    logic        last_err;

    function automatic logic [31:0] seg_base(input logic [1:0] s);
        if (s == 2'd0) return 32'h0040_0000;
        if (s == 2'd1) return 32'h1001_0000;
        return 32'h0;
    endfunction

    always @(negedge clk) begin
        bit exp_ready, exp_v;
        cyc++;
        if (!rst_n) begin
            rel_cnt = 0;
            busy    = 0;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_rsp_badvaddr", rsp_badvaddr, 0);
            chk("rst_rsp_valid0", rsp_valid0, 0);
        end else begin
            if (rel_cnt < 3) rel_cnt++;
            exp_ready = !busy && rel_cnt >= 2;
            chk("req_ready", req_ready, exp_ready);
            if (rsp_valid && !prev_valid) dut_lat = cyc - acc_cyc;
            if (busy) begin
                exp_v = (cyc >= acc_cyc + WAITC + 1);
                chk("rsp_valid", rsp_valid, exp_v);
                if (exp_v) begin
                    if (cyc == acc_cyc + WAITC + 1 && e_we && !e_err) begin
                        logic [31:0] w;
                        w = mem_m.exists(e_addr / 4) ? mem_m[e_addr / 4] : 32'h0;
                        for (int i = 0; i < 4; i++)
                            if (e_be[i]) w[8*i +: 8] = e_wdata[8*i +: 8];
                        mem_m[e_addr / 4] = w;
                    end
                    chk("rsp_err", rsp_err, e_err);
                    chk("rsp_badvaddr", rsp_badvaddr, e_bva);
                    if (e_err || e_rknown) chk("rsp_rdata", rsp_rdata, e_rdata);
                    if (rsp_ready) begin
                        busy       = 0;
                        last_rdata = rsp_rdata;
                        last_err   = rsp_err;
                        last_bva   = rsp_badvaddr;
                    end
                end
            end else begin
                chk("rsp_valid_idle", rsp_valid, 0);
            end
            if (exp_ready && req_valid) begin
                busy     = 1;
                acc_cyc  = cyc;
                e_we     = req_we;
                e_be     = req_be;
                e_addr   = req_addr;
                e_wdata  = req_wdata;
                e_err    = (req_be == 4'b0000) || (req_addr % 4 != 0) || (req_addr / 4 >= DEPTH);
                e_bva    = e_err ? req_addr + seg_base(req_seg) : 32'h0;
                e_rknown = 0;
                e_rdata  = 32'h0;
                if (!e_err && !req_we && mem_m.exists(req_addr / 4)) begin
                    e_rknown = 1;
                    for (int i = 0; i < 4; i++)
                        if (req_be[i]) e_rdata[8*i +: 8] = mem_m[req_addr / 4][8*i +: 8];
                end
            end
        end
        prev_valid = rsp_valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_req(input logic we, input logic [3:0] be, input logic [1:0] seg,
                             input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk); #1;
        req_valid = 1; req_we = we; req_be = be; req_seg = seg;
        req_addr = addr; req_wdata = wdata;
    endtask

    task automatic wait_accept(output int t);
        t = 0;
        do begin @(negedge clk); t++; end while (!req_ready && t < 40);
        if (t >= 40) chk("accept_timeout", 1, 0);
        @(posedge clk); #1;
        req_valid = 0;
        req_we = 1; req_be = 4'hF; req_seg = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic get_rsp(input int hold, input bit early);
        int t = 0;
        if (early) rsp_ready = 1;
        do begin @(negedge clk); t++; end while (!rsp_valid && t < 40);
        if (t >= 40) chk("rsp_timeout", 1, 0);
        if (!early) begin
            repeat (hold) @(negedge clk);
            @(posedge clk); #1;
            rsp_ready = 1;
        end
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    task automatic xact(input logic we, input logic [3:0] be, input logic [1:0] seg,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit early);
        int t;
        drive_req(we, be, seg, addr, wdata);
        wait_accept(t);
        get_rsp(0, early);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n = 0; req_valid = 0; req_we = 0; req_be = 0; req_seg = 0;
        req_addr = 0; req_wdata = 0; rsp_ready = 0; req_valid0 = 0; rsp_ready0 = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        repeat (2) @(posedge clk);

        // full-word write then read, latency pinned
        xact(1, 4'b1111, 2'd1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        chk("lat_write", dut_lat, 3);
        xact(0, 4'b1111, 2'd1, 32'h0000_0010, 32'h0, 0);
        chk("rd_full", last_rdata, 32'hDEAD_BEEF);
        chk("rd_full_err", last_err, 0);
        chk("lat_read", dut_lat, 3);

        // byte-lane write and masked reads
        xact(1, 4'b0010, 2'd1, 32'h0000_0010, 32'h0000_5500, 0);
        xact(0, 4'b1111, 2'd1, 32'h0000_0010, 32'h0, 1);
        chk("rd_lane", last_rdata, 32'hDEAD_55EF);
        xact(0, 4'b1100, 2'd1, 32'h0000_0010, 32'h0, 0);
        chk("rd_upper", last_rdata, 32'hDEAD_0000);

        // out-of-range: read and write fault, word 0 (alias index) untouched
        xact(1, 4'b1111, 2'd0, 32'h0000_0000, 32'hCAFE_F00D, 0);
        xact(0, 4'b1111, 2'd1, 32'h0000_2000, 32'h0, 0);
        chk("oor_err", last_err, 1);
        chk("oor_bva", last_bva, 32'h1001_2000);
        chk("oor_rdata", last_rdata, 32'h0);
        xact(1, 4'b1111, 2'd1, 32'h0000_2000, 32'h1234_5678, 0);
        chk("oor_wr_err", last_err, 1);
        xact(0, 4'b1111, 2'd0, 32'h0000_0000, 32'h0, 0);
        chk("oor_wr_nochange", last_rdata, 32'hCAFE_F00D);

        // misaligned and empty byte-enable faults
        xact(0, 4'b1111, 2'd0, 32'h0000_0006, 32'h0, 0);
        chk("misal_err", last_err, 1);
        chk("misal_bva", last_bva, 32'h0040_0006);
        xact(0, 4'b0000, 2'd2, 32'h0000_0010, 32'h0, 0);
        chk("be0_err", last_err, 1);
        chk("be0_bva", last_bva, 32'h0000_0010);
        xact(0, 4'b1111, 2'd3, 32'hFFFF_FFFC, 32'h0, 0);
        chk("seg3_bva", last_bva, 32'hFFFF_FFFC);

        // back-pressure: response held 5 cycles while a new request waits
        drive_req(0, 4'b1111, 2'd1, 32'h0000_0010, 32'h0);
        wait_accept(t);
        t = 0;
        do begin @(negedge clk); t++; end while (!rsp_valid && t < 40);
        @(posedge clk); #1;
        req_valid = 1; req_we = 1; req_be = 4'b1111; req_seg = 2'd1;
        req_addr = 32'h0000_0010; req_wdata = 32'h0BAD_F00D;
        repeat (5) @(negedge clk);
        @(posedge clk); #1 rsp_ready = 1;
        @(posedge clk); #1 rsp_ready = 0;
        chk("hold_rdata", last_rdata, 32'hDEAD_55EF);
        wait_accept(t);
        chk("turnaround", t, 1);
        get_rsp(0, 0);
        xact(0, 4'b1111, 2'd1, 32'h0000_0010, 32'h0, 0);
        chk("after_hold", last_rdata, 32'h0BAD_F00D);

        // reset during the wait states of a write to word 4
        drive_req(1, 4'b1111, 2'd1, 32'h0000_0010, 32'h7777_7777);
        wait_accept(t);
        rst_n = 0;
        #1;
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        xact(0, 4'b1111, 2'd1, 32'h0000_0010, 32'h0, 0);
        chk("midrst_word4", last_rdata, 32'h0BAD_F00D);

        // zero-wait-state instance
        @(posedge clk); #1;
        req_we = 1; req_be = 4'b1111; req_seg = 2'd1; req_addr = 32'h0000_0004;
        req_wdata = 32'h5A5A_1234; req_valid0 = 1; rsp_ready0 = 1;
        @(negedge clk) chk("w0_ready", req_ready0, 1);
        @(posedge clk); #1 req_valid0 = 0;
        @(negedge clk);
        chk("w0_wr_valid", rsp_valid0, 1);
        chk("w0_wr_err", rsp_err0, 0);
        @(negedge clk);
        chk("w0_consumed", rsp_valid0, 0);
        chk("w0_ready_again", req_ready0, 1);
        @(posedge clk); #1;
        req_we = 0; req_valid0 = 1;
        @(posedge clk); #1 req_valid0 = 0;
        @(negedge clk);
        chk("w0_rd_valid", rsp_valid0, 1);
        chk("w0_rd_data", rsp_rdata0, 32'h5A5A_1234);
        @(posedge clk); #1 rsp_ready0 = 0;

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
